// File: rtl/wb_master_if.sv
// Single-outstanding Wishbone master bridging CPU load/store requests onto the bus,
// with optional cycle timeout, pipeline flush and stall-hold of the returned data.
module wb_master_if #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  output logic        bus_err_o,
  input  logic [31:0] wb_data_i,
  input  logic        wb_ack_i,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o
);

  typedef enum logic [1:0] {IDLE, BUSY, WAIT_STALL} state_t;

  // Counter only has to reach TIMEOUT-1: the abort happens on that BUSY cycle.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t          state_reg;
  logic [31:0]     rd_buf_reg;
  logic [CW-1:0]   cnt_reg;
  logic            timeout_hit;
  logic            bus_done;

  assign timeout_hit = (TIMEOUT != 0) && (state_reg == BUSY) && !wb_ack_i
                       && (cnt_reg == TO_LAST);
  assign bus_done    = (state_reg == BUSY) && (flush_i || wb_ack_i || timeout_hit);

  assign stallreq_o = ((state_reg == IDLE) && cpu_ce_i && !flush_i) ||
                      ((state_reg == BUSY) && !wb_ack_i && !timeout_hit);

  assign cpu_data_o = ((state_reg == BUSY) && wb_ack_i && !wb_we_o) ? wb_data_i : rd_buf_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      rd_buf_reg <= '0;
      cnt_reg    <= '0;
      bus_err_o  <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
      wb_we_o    <= 1'b0;
      wb_sel_o   <= '0;
      wb_stb_o   <= 1'b0;
      wb_cyc_o   <= 1'b0;
    end else begin
      bus_err_o <= 1'b0;
      if (bus_done) begin
        wb_addr_o <= '0;
        wb_data_o <= '0;
        wb_we_o   <= 1'b0;
        wb_sel_o  <= '0;
        wb_stb_o  <= 1'b0;
        wb_cyc_o  <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wb_addr_o <= cpu_addr_i;
            wb_data_o <= cpu_data_i;
            wb_we_o   <= cpu_we_i;
            wb_sel_o  <= cpu_sel_i;
            wb_stb_o  <= 1'b1;
            wb_cyc_o  <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // Flush beats ack, and an ack in the final cycle beats the timeout.
          if (flush_i) begin
            rd_buf_reg <= '0;
            state_reg  <= IDLE;
          end else if (wb_ack_i) begin
            if (!wb_we_o) rd_buf_reg <= wb_data_i;
            state_reg <= (stall_i != 6'd0) ? WAIT_STALL : IDLE;
          end else if (timeout_hit) begin
            rd_buf_reg <= ERR_WORD;
            bus_err_o  <= 1'b1;
            state_reg  <= (stall_i != 6'd0) ? WAIT_STALL : IDLE;
          end else if (TIMEOUT != 0) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        WAIT_STALL: begin
          if (flush_i) begin
            rd_buf_reg <= '0;
            state_reg  <= IDLE;
          end else if (stall_i == 6'd0) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
